emergency_scheduler: RTL

Sequential preemption controller for the intersection's emergency path. It sits between the normal signal controller and the lamp drivers. It turns per-lane emergency requests into a safe sequence (yellow clear, fixed green hold, all-red) for one direction group at a time, and shares the preemption slot between competing groups round-robin. It replaces the combinational pair-OR emergency path and drives the remaining-time value as a counter rather than a constant.

---
 rtl/emergency_scheduler_pkg.sv | 29 ++
 rtl/emergency_scheduler_if.sv | 34 +++
 rtl/emergency_scheduler_rr_arbiter.sv | 33 +++
 rtl/emergency_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/emergency_scheduler_pkg.sv
// Shared definitions for the emergency preemption scheduler.
//   - state_t      : scheduler FSM states
//   - NUM_GROUPS   : number of direction groups (two lanes each)
//   - LANES        : lamp lanes driven by the scheduler
//   - TIME_W       : width of the remaining-time counter
//   - group_mask() : lane mask of a direction group (lanes 2g and 2g+1)
package emergency_pkg;

    localparam int NUM_GROUPS = 4;
    localparam int LANES      = 8;
    localparam int TIME_W     = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        SERVE   = 2'd2,
        ALL_RED = 2'd3
    } state_t;

    // Lane vectors are indexed [0:7]; group g owns lanes 2g and 2g+1.
    function automatic logic [0:LANES-1] group_mask(input logic [1:0] g);
        logic [0:LANES-1] m;
        m = '0;
        m[{g, 1'b0}] = 1'b1;
        m[{g, 1'b1}] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/emergency_scheduler_if.sv
// Signal bundle between the normal controller / lamp drivers and the
// emergency scheduler.
//   tick           : one-cycle timebase enable
//   emergency_lane : per-lane emergency request (level)
//   normal_lane    : green lanes from the normal controller
//   lane_output    : final green to lamp drivers
//   lane_yellow    : final yellow to lamp drivers
//   preempt_active : scheduler is not idle
//   grant_group    : group being served or cleared for
//   load_time      : ticks remaining in the current timed state
// Modports: master = environment side, slave = scheduler side.
interface emergency_scheduler_if;
    import emergency_pkg::*;

    logic                tick;
    logic [0:LANES-1]    emergency_lane;
    logic [0:LANES-1]    normal_lane;
    logic [0:LANES-1]    lane_output;
    logic [0:LANES-1]    lane_yellow;
    logic                preempt_active;
    logic [1:0]          grant_group;
    logic [TIME_W-1:0]   load_time;

    modport master (
        output tick, emergency_lane, normal_lane,
        input  lane_output, lane_yellow, preempt_active, grant_group, load_time
    );

    modport slave (
        input  tick, emergency_lane, normal_lane,
        output lane_output, lane_yellow, preempt_active, grant_group, load_time
    );

endinterface

// File: rtl/emergency_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter for the preemption slot.
//   req        : per-group request vector
//   last_grant : most recently granted group
//   grant      : winning group (nearest index after last_grant, wrapping)
//   valid      : at least one group is requesting
// The group that was granted last has the lowest priority, so a group
// requesting continuously wins again only when nobody else requests.
module emergency_rr_arbiter
    import emergency_pkg::*;
(
    input  logic [NUM_GROUPS-1:0] req,
    input  logic [1:0]            last_grant,
    output logic [1:0]            grant,
    output logic                  valid
);

    logic [1:0] idx;

    // Scan from farthest to nearest candidate so the nearest one wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_GROUPS; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/emergency_scheduler.sv
// Emergency preemption scheduler. Turns per-lane emergency requests into a
// yellow-clear / green-hold / all-red sequence for one direction group at a
// time, sharing the slot between groups round-robin.
//   clk, reset_n : clock, asynchronous active-low reset
//   sched        : emergency_scheduler_if.slave (tick, lane inputs, lamp
//                  outputs, preempt_active, grant_group, load_time)
// Optional feature macro EMERGENCY_EXTEND_EN: a group that is still the only
// requester when its hold expires gets its hold reloaded, up to a total of
// MAX_EXTEND_TICKS per grant.
module emergency_scheduler
    import emergency_pkg::*;
#(
    parameter int HOLD_TICKS       = 4,
    parameter int YELLOW_TICKS     = 2,
    parameter int ALL_RED_TICKS    = 1,
    parameter int MAX_EXTEND_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    emergency_scheduler_if.slave  sched
);

    localparam logic [TIME_W-1:0] HOLD_T    = TIME_W'(HOLD_TICKS);
    localparam logic [TIME_W-1:0] YELLOW_T  = TIME_W'(YELLOW_TICKS);
    localparam logic [TIME_W-1:0] ALL_RED_T = TIME_W'(ALL_RED_TICKS);
    localparam logic [TIME_W-1:0] ONE_T     = TIME_W'(1);

    state_t                 state_q, state_d;
    logic [TIME_W-1:0]      timer_q, timer_d;
    logic [0:LANES-1]       snap_q, snap_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             last_q, last_d;
    logic [NUM_GROUPS-1:0]  req_q, group_req;
    logic [0:LANES-1]       out_q, out_d;
    logic [0:LANES-1]       yel_q, yel_d;
    logic                   active_q, active_d;
    logic [0:LANES-1]       mask_d;
    logic [1:0]             arb_grant;
    logic                   arb_valid;
    logic                   expire;
    logic                   leave_serve;
    logic                   rearb;

`ifdef EMERGENCY_EXTEND_EN
    localparam int               EXT_W  = TIME_W + 1;
    localparam logic [EXT_W-1:0] MAX_T  = EXT_W'(MAX_EXTEND_TICKS);
    localparam logic [EXT_W-1:0] HOLD_E = EXT_W'(HOLD_TICKS);

    // ext_q: hold ticks already allotted to the current grant.
    logic [EXT_W-1:0] ext_q, ext_d;
    logic [EXT_W-1:0] allowance, extend_amt;
    logic             extend_ok;

    always_comb begin
        allowance  = (ext_q < MAX_T) ? (MAX_T - ext_q) : '0;
        extend_amt = (allowance < HOLD_E) ? allowance : HOLD_E;
        extend_ok  = req_q[grant_q]
                     && !(|(req_q & ~(NUM_GROUPS'(1) << grant_q)))
                     && (allowance != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ext_q <= '0;
        else          ext_q <= ext_d;
    end
`else
    // The extension cap only matters when the extension feature is built in.
    localparam int unused_max_extend = MAX_EXTEND_TICKS;
`endif

    always_comb begin
        group_req = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_req[g] = sched.emergency_lane[2*g] | sched.emergency_lane[2*g+1];
        end
    end

    emergency_rr_arbiter u_arb (
        .req        (req_q),
        .last_grant (last_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Timed states expire on the tick that finds the timer at 1; the timer is
    // loaded on entry, so a tick on the entry edge is never counted.
    assign expire = (state_q != IDLE) && sched.tick && (timer_q == ONE_T);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        snap_d      = snap_q;
        grant_d     = grant_q;
        last_d      = last_q;
        leave_serve = 1'b0;
        rearb       = 1'b0;
`ifdef EMERGENCY_EXTEND_EN
        ext_d       = ext_q;
`endif

        if ((state_q != IDLE) && sched.tick && (timer_q != ONE_T)) begin
            timer_d = timer_q - ONE_T;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    last_d  = arb_grant;
                    snap_d  = sched.normal_lane;
`ifdef EMERGENCY_EXTEND_EN
                    ext_d   = HOLD_E;
`endif
                    if ((YELLOW_TICKS > 0)
                        && (|(sched.normal_lane & ~group_mask(arb_grant)))) begin
                        state_d = CLEAR;
                        timer_d = YELLOW_T;
                    end else begin
                        state_d = SERVE;
                        timer_d = HOLD_T;
                    end
                end
            end
            CLEAR: begin
                if (expire) begin
                    state_d = SERVE;
                    timer_d = HOLD_T;
                end
            end
            SERVE: begin
                if (expire) begin
`ifdef EMERGENCY_EXTEND_EN
                    if (extend_ok) begin
                        timer_d = extend_amt[TIME_W-1:0];
                        ext_d   = ext_q + extend_amt;
                    end else begin
                        leave_serve = 1'b1;
                    end
`else
                    leave_serve = 1'b1;
`endif
                    if (leave_serve) begin
                        if (ALL_RED_TICKS > 0) begin
                            state_d = ALL_RED;
                            timer_d = ALL_RED_T;
                        end else begin
                            rearb = 1'b1;
                        end
                    end
                end
            end
            ALL_RED: begin
                if (expire) rearb = 1'b1;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // After an all-red gap the lanes are already red, so a pending
        // request goes straight to SERVE without a yellow clearance.
        if (rearb) begin
            if (arb_valid) begin
                state_d = SERVE;
                timer_d = HOLD_T;
                grant_d = arb_grant;
                last_d  = arb_grant;
`ifdef EMERGENCY_EXTEND_EN
                ext_d   = HOLD_E;
`endif
            end else begin
                state_d = IDLE;
                timer_d = '0;
            end
        end
    end

    // Lamp outputs are computed from the next state so they register on the
    // same edge as the state change.
    always_comb begin
        mask_d   = group_mask(grant_d);
        out_d    = '0;
        yel_d    = '0;
        active_d = (state_d != IDLE);
        case (state_d)
            IDLE:    out_d = sched.normal_lane;
            CLEAR: begin
                out_d = snap_d & mask_d;
                yel_d = snap_d & ~mask_d;
            end
            SERVE:   out_d = mask_d;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            snap_q   <= '0;
            grant_q  <= '0;
            last_q   <= 2'd3;
            req_q    <= '0;
            out_q    <= '0;
            yel_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            snap_q   <= snap_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            req_q    <= group_req;
            out_q    <= out_d;
            yel_q    <= yel_d;
            active_q <= active_d;
        end
    end

    assign sched.lane_output    = out_q;
    assign sched.lane_yellow    = yel_q;
    assign sched.preempt_active = active_q;
    assign sched.grant_group    = grant_q;
    assign sched.load_time      = timer_q;

endmodule
